// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the fetch / load-store bus arbiter: FSM states,
// watchdog limit, constant words and the registered bus command layout.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } arb_state_t;

  localparam logic [7:0]  ArbTimeout = 8'd255;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [3:0]  AllBytes   = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_cmd_t;

  // Fetch is always a full-word read.
  function automatic bus_cmd_t if_cmd(input logic [29:0] word_addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.addr  = word_addr;
    c.be    = AllBytes;
    c.wdata = ZeroWord;
    return c;
  endfunction

  function automatic bus_cmd_t mem_cmd(input logic        we,
                                       input logic [29:0] word_addr,
                                       input logic [3:0]  sel,
                                       input logic [31:0] wdata);
    bus_cmd_t c;
    c.we    = we;
    c.addr  = word_addr;
    c.be    = sel;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// 8-bit busy-cycle watchdog for bus_arbiter; only instantiated when
// ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] r_count;

  // Saturates at the limit so a stalled owner cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != ArbTimeout)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == ArbTimeout);

endmodule

// File: rtl/bus_arbiter.sv
// Two-client (fetch / load-store) arbiter onto one SRAM port, MEM priority,
// no preemption. Optional bus watchdog enabled by macro ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_req_if,
  output logic        stall_req_mem
);

  arb_state_t  r_state;
  bus_cmd_t    r_cmd;
  logic        r_bus_req;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_done;
  logic        r_mem_done;
  logic        w_busy;
  logic        w_unused_addr_lsbs;

  assign w_busy             = (r_state != IDLE);
  assign w_unused_addr_lsbs = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef ARB_TIMEOUT_EN
  logic w_expired;
  logic r_if_err;
  logic r_mem_err;

  arb_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_busy),
    .enable  (w_busy && !bus_ack),
    .expired (w_expired)
  );

  assign if_err  = r_if_err;
  assign mem_err = r_mem_err;
`else
  assign if_err  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_bus_req   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_if_err    <= 1'b0;
      r_mem_err   <= 1'b0;
`endif
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_if_err   <= 1'b0;
      r_mem_err  <= 1'b0;
`endif
      if (!w_busy) begin
        // bus_ack is deliberately not looked at while idle.
        if (mem_req) begin
          r_state   <= MEM_BUSY;
          r_bus_req <= 1'b1;
          r_cmd     <= mem_cmd(mem_we, mem_addr[31:2], mem_sel, mem_wdata);
        end else if (if_req) begin
          r_state   <= IF_BUSY;
          r_bus_req <= 1'b1;
          r_cmd     <= if_cmd(if_addr[31:2]);
        end else begin
          r_state   <= IDLE;
        end
      end else if (bus_ack) begin
        r_state   <= IDLE;
        r_bus_req <= 1'b0;
        if (r_state == IF_BUSY) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= bus_rdata;
        end else begin
          r_mem_done <= 1'b1;
          if (!r_cmd.we) begin
            r_mem_rdata <= bus_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
      end else if (w_expired) begin
        r_state   <= IDLE;
        r_bus_req <= 1'b0;
        if (r_state == IF_BUSY) begin
          r_if_done <= 1'b1;
          r_if_err  <= 1'b1;
        end else begin
          r_mem_done <= 1'b1;
          r_mem_err  <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_cmd.we;
  assign bus_addr  = r_cmd.addr;
  assign bus_be    = r_cmd.be;
  assign bus_wdata = r_cmd.wdata;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_done   = r_if_done;
  assign mem_done  = r_mem_done;

  assign stall_req_if  = if_req  & ~r_if_done;
  assign stall_req_mem = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions against a transaction-level model of arbitration and read data.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_req_if;
  logic        stall_req_mem;

  int checks = 0;
  int errors = 0;

  // Model: the last word each client has received.
  logic [31:0] m_if_rdata;
  logic [31:0] m_mem_rdata;

  bus_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_done       (if_done),
    .if_err        (if_err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_sel       (mem_sel),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .mem_err       (mem_err),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .stall_req_if  (stall_req_if),
    .stall_req_mem (stall_req_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Bus slave for one granted access; called on the negedge where the grant
  // is first visible, returns on the negedge showing done.
  task automatic serve(input bit client, input logic exp_we, input logic [29:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input int unsigned lat, input logic [31:0] rdata, input bit drop_early);
    logic [69:0] exp_bus;
    logic        exp_done_if;
    logic        exp_done_mem;
    exp_bus = {1'b1, exp_we, exp_addr, exp_be, exp_wd, 2'b00};
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_done, mem_done} !== exp_bus) begin
      errors++;
      $display("FAIL grant_fields got %h exp %h", {bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_done, mem_done}, exp_bus);
    end
    if (drop_early) begin
      if (client) mem_req = 1'b0;
      else        if_req  = 1'b0;
    end
    for (int unsigned i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_done, mem_done} !== exp_bus) begin
        errors++;
        $display("FAIL hold_stable cyc %0d got %h exp %h", i, {bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_done, mem_done}, exp_bus);
      end
      checks++;
      if ({stall_req_if, stall_req_mem} !== {if_req, mem_req}) begin
        errors++;
        $display("FAIL stall_busy got %b exp %b", {stall_req_if, stall_req_mem}, {if_req, mem_req});
      end
    end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    @(negedge clk);
    if (!client)      m_if_rdata  = rdata;
    else if (!exp_we) m_mem_rdata = rdata;
    exp_done_if  = !client;
    exp_done_mem = client;
    checks++;
    if ({bus_req, if_done, mem_done, if_err, mem_err, if_rdata, mem_rdata} !==
        {1'b0, exp_done_if, exp_done_mem, 2'b00, m_if_rdata, m_mem_rdata}) begin
      errors++;
      $display("FAIL done_cycle got %h exp %h", {bus_req, if_done, mem_done, if_err, mem_err, if_rdata, mem_rdata},
               {1'b0, exp_done_if, exp_done_mem, 2'b00, m_if_rdata, m_mem_rdata});
    end
    checks++;
    if ({stall_req_if, stall_req_mem} !== {if_req & ~exp_done_if, mem_req & ~exp_done_mem}) begin
      errors++;
      $display("FAIL stall_done got %b exp %b", {stall_req_if, stall_req_mem}, {if_req & ~exp_done_if, mem_req & ~exp_done_mem});
    end
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (client) mem_req = 1'b0;
    else        if_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
    mem_sel = '0; mem_wdata = '0; bus_rdata = 32'hDEAD_BEEF; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, if_err, mem_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, if_err, mem_err});
    end
    rst = 1'b0;
    m_if_rdata = '0; m_mem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({bus_req, if_done, mem_done, stall_req_if, stall_req_mem} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 00000", {bus_req, if_done, mem_done, stall_req_if, stall_req_mem});
    end
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h8000_0004;
    @(negedge clk);
    serve(1'b0, 1'b0, 30'h2000_0001, 4'b1111, 32'h0, 2, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus_req, if_done, if_rdata} !== {2'b00, 32'h1234_5678}) begin
      errors++;
      $display("FAIL if_done_single got %h exp %h", {bus_req, if_done, if_rdata}, {2'b00, 32'h1234_5678});
    end
  endtask

  task automatic test_idle_ack();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, if_done, mem_done, if_rdata, mem_rdata} !== {3'b000, m_if_rdata, m_mem_rdata}) begin
      errors++;
      $display("FAIL idle_ack got %h exp %h", {bus_req, if_done, mem_done, if_rdata, mem_rdata}, {3'b000, m_if_rdata, m_mem_rdata});
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0001; mem_addr = 32'h8000_0100; mem_wdata = 32'h0000_00AB;
    @(negedge clk);
    serve(1'b1, 1'b1, 30'h2000_0040, 4'b0001, 32'h0000_00AB, 2, 32'h5555_AAAA, 1'b0);
    @(negedge clk);
    serve(1'b0, 1'b0, 30'h0000_0010, 4'b1111, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    // MEM raised mid-fetch waits; a fetch re-raised at completion then loses.
    if_req = 1'b1; if_addr = 32'h0000_1000;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1100; mem_addr = 32'h0000_2008; mem_wdata = 32'hFFFF_FFFF;
    serve(1'b0, 1'b0, 30'h0000_0400, 4'b1111, 32'h0, 3, 32'h1111_2222, 1'b0);
    if_req = 1'b1; if_addr = 32'h0000_1004;
    @(negedge clk);
    serve(1'b1, 1'b0, 30'h0000_0802, 4'b1100, 32'hFFFF_FFFF, 1, 32'h3333_4444, 1'b0);
    @(negedge clk);
    serve(1'b0, 1'b0, 30'h0000_0401, 4'b1111, 32'h0, 0, 32'h5555_6666, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0100; mem_wdata = '0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_grant got %b exp 1", bus_req);
    end
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    m_if_rdata = '0; m_mem_rdata = '0;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, if_err, mem_err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 0", {bus_req, bus_we, bus_addr, bus_be, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, if_err, mem_err});
    end
    @(negedge clk);
    checks++;
    if ({bus_req, mem_done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_nodone got %b exp 00", {bus_req, mem_done});
    end
  endtask

  task automatic test_random();
    bit          do_if, do_mem;
    logic [31:0] ia;
    for (int n = 0; n < 40; n++) begin
      do_mem = ($urandom_range(0, 2) != 0);
      do_if  = !do_mem || ($urandom_range(0, 1) == 1);
      ia     = $urandom;
      if_req  = do_if;  if_addr = ia;
      mem_req = do_mem; mem_we = $urandom_range(0, 1); mem_sel = $urandom;
      mem_addr = $urandom; mem_wdata = $urandom;
      @(negedge clk);
      if (do_mem) begin
        serve(1'b1, mem_we, mem_addr[31:2], mem_sel, mem_wdata, $urandom_range(0, 3), $urandom,
              $urandom_range(0, 3) == 0);
        if (do_if) @(negedge clk);
      end
      if (do_if) begin
        serve(1'b0, 1'b0, ia[31:2], 4'b1111, 32'h0, $urandom_range(0, 3), $urandom,
              $urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int unsigned waited;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0800; mem_wdata = '0;
    @(negedge clk);
    waited = 0;
`ifdef ARB_TIMEOUT_EN
    while (!mem_done && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!mem_done || waited < 250 || waited > 260) begin
      errors++;
      $display("FAIL timeout_done got done=%b after %0d cycles exp done=1 near 256", mem_done, waited);
    end
    checks++;
    if ({bus_req, mem_err, if_done, mem_rdata} !== {3'b010, m_mem_rdata}) begin
      errors++;
      $display("FAIL timeout_err got %h exp %h", {bus_req, mem_err, if_done, mem_rdata}, {3'b010, m_mem_rdata});
    end
    mem_req = 1'b0;
    @(negedge clk);
`else
    repeat (300) begin
      @(negedge clk);
      if (mem_done) waited++;
    end
    checks++;
    if ({bus_req, mem_err, waited} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL no_timeout got req=%b err=%b dones=%0d exp req=1 err=0 dones=0", bus_req, mem_err, waited);
    end
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_idle_ack();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
